// File: rtl/matmul_arbiter.sv
// Round-robin, credit-checked arbiter sharing one fixed-latency matrix multiplier among NUM_REQ
// requesters. Optional perf counters are enabled by defining MATMUL_ARB_PERF_EN.
module matmul_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned A_ROWS           = 2,
  parameter int unsigned B_COLUMNS        = 2,
  parameter int unsigned A_COLUMNS_B_ROWS = 2,
  parameter int unsigned C_DATA_WIDTH     = 2 * DATA_WIDTH + $clog2(A_COLUMNS_B_ROWS),
  parameter int unsigned MM_LATENCY       = 1,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned ID_W             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                                          clk_i,
  input  logic                                                          reset_ni,
  input  logic [NUM_REQ-1:0]                                            req_valid_i,
  output logic [NUM_REQ-1:0]                                            req_ready_o,
  input  logic [NUM_REQ-1:0][A_ROWS*A_COLUMNS_B_ROWS-1:0][DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ-1:0][A_COLUMNS_B_ROWS*B_COLUMNS-1:0][DATA_WIDTH-1:0] req_b_i,
  output logic                                                          mm_valid_o,
  output logic [A_ROWS*A_COLUMNS_B_ROWS-1:0][DATA_WIDTH-1:0]            mm_a_o,
  output logic [A_COLUMNS_B_ROWS*B_COLUMNS-1:0][DATA_WIDTH-1:0]         mm_b_o,
  input  logic                                                          mm_valid_i,
  input  logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]                 mm_c_i,
  output logic                                                          resp_valid_o,
  input  logic                                                          resp_ready_i,
  output logic [ID_W-1:0]                                               resp_id_o,
  output logic [A_ROWS*B_COLUMNS-1:0][C_DATA_WIDTH-1:0]                 resp_c_o,
`ifdef MATMUL_ARB_PERF_EN
  output logic [NUM_REQ-1:0][15:0]                                      perf_grants_o,
  output logic [15:0]                                                   perf_stall_o,
`endif
  output logic                                                          err_o
);

  localparam int unsigned NA   = A_ROWS * A_COLUMNS_B_ROWS;
  localparam int unsigned NB   = A_COLUMNS_B_ROWS * B_COLUMNS;
  localparam int unsigned NC   = A_ROWS * B_COLUMNS;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic                              mm_valid_q;
  logic [NA-1:0][DATA_WIDTH-1:0]     mm_a_q;
  logic [NB-1:0][DATA_WIDTH-1:0]     mm_b_q;
  logic [ID_W-1:0]                   mm_id_q;
  logic [MM_LATENCY-1:0]             tag_v_q;
  logic [MM_LATENCY-1:0][ID_W-1:0]   tag_id_q;
  logic [ID_W-1:0]                   rr_q, rr_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [CntW-1:0]                   fcnt_q, fcnt_d;
  logic [PtrW-1:0]                   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NC-1:0][C_DATA_WIDTH-1:0]   mem_c_q [FIFO_DEPTH];
  logic [ID_W-1:0]                   mem_id_q [FIFO_DEPTH];
  logic                              err_q, err_d;

  logic            gnt_found, credit_ok, accept, pop, wr_en;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   cand;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (ID_W + 1)'(i);
      if (cand >= (ID_W + 1)'(NUM_REQ)) cand = cand - (ID_W + 1)'(NUM_REQ);
      if (!gnt_found && req_valid_i[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign credit_ok = (cnt_q < CntW'(FIFO_DEPTH));
  assign accept    = credit_ok && gnt_found;
  assign pop       = resp_valid_o && resp_ready_i;
  assign wr_en     = tag_v_q[MM_LATENCY-1];

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CntW'(1);

    fcnt_d = fcnt_q;
    if (wr_en && !pop)      fcnt_d = fcnt_q + CntW'(1);
    else if (!wr_en && pop) fcnt_d = fcnt_q - CntW'(1);

    wptr_d = wptr_q;
    if (wr_en) wptr_d = (wptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    rptr_d = rptr_q;
    if (pop) rptr_d = (rptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);

    // Any disagreement between the multiplier and our own tag pipe is latched.
    err_d = err_q | (mm_valid_i != tag_v_q[MM_LATENCY-1]);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      mm_valid_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_id_q    <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_c_q[i]  <= '0;
        mem_id_q[i] <= '0;
      end
    end else begin
      mm_valid_q <= accept;
      if (accept) begin
        mm_a_q  <= req_a_i[gnt_idx];
        mm_b_q  <= req_b_i[gnt_idx];
        mm_id_q <= gnt_idx;
      end
      tag_v_q[0]  <= mm_valid_q;
      tag_id_q[0] <= mm_id_q;
      for (int unsigned s = 1; s < MM_LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      if (wr_en) begin
        mem_c_q[wptr_q]  <= mm_c_i;
        mem_id_q[wptr_q] <= tag_id_q[MM_LATENCY-1];
      end
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  assign mm_valid_o   = mm_valid_q;
  assign mm_a_o       = mm_a_q;
  assign mm_b_o       = mm_b_q;
  assign resp_valid_o = (fcnt_q != '0);
  assign resp_c_o     = mem_c_q[rptr_q];
  assign resp_id_o    = mem_id_q[rptr_q];
  assign err_o        = err_q;

`ifdef MATMUL_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_grants_q;
  logic [15:0]              perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept && perf_grants_q[gnt_idx] != 16'hffff) begin
        perf_grants_q[gnt_idx] <= perf_grants_q[gnt_idx] + 16'd1;
      end
      if ((|req_valid_i) && !credit_ok && perf_stall_q != 16'hffff) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_grants_o = perf_grants_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule
